// File: rtl/data_read_capture_pkg.sv
// Shared definitions for the data_read capture path: FSM states, status-register
// layout and AXI-lite register map used by the write/read slaves.
package data_read_capture_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_CAPTURE = 2'd1,
    CAP_DONE    = 2'd2
  } cap_state_e;

  localparam int unsigned SR_BUSY      = 0;
  localparam int unsigned SR_DONE      = 1;
  localparam int unsigned SR_OVR       = 2;
  localparam int unsigned SR_COUNT_LSB = 16;

  localparam logic [11:0] AXI_ADDR_SR  = 12'h004;
  localparam logic [11:0] AXI_ADDR_BUF = 12'h800;

  // Packs capture status into the SR word as seen by the AXI read slave.
  function automatic logic [31:0] sr_word(input logic        busy,
                                          input logic        done,
                                          input logic        ovr,
                                          input logic [15:0] count);
    logic [31:0] w;
    w                       = '0;
    w[SR_BUSY]              = busy;
    w[SR_DONE]              = done;
    w[SR_OVR]               = ovr;
    w[SR_COUNT_LSB +: 16]   = count;
    return w;
  endfunction

endpackage

// File: rtl/data_read_buf.sv
// Simple dual-port capture buffer: one synchronous write port, one synchronous
// read-first read port. No reset so it maps onto block RAM.
module data_read_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_read_capture.sv
// Captures a DEPTH-sample burst from the external data port on each accepted
// CR.START and exposes busy/done/overrun/count status plus a buffer read port.
module data_read_capture
  import data_read_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              cr_start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [ADDR_W-1:0] buf_raddr,
  output logic [31:0]       buf_rdata,
  output logic              sr_busy,
  output logic              sr_done,
  output logic              sr_ovr,
  output logic [ADDR_W:0]   sr_count
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  cap_state_e        r_state;
  cap_state_e        w_state_nxt;
  logic              w_we;
  logic              w_last;
  logic              w_start;
  logic [ADDR_W:0]   r_count;
  logic              r_busy;
  logic              r_done;
  logic              r_ovr;
  logic              r_rd_ok;
  logic [DATA_W-1:0] w_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_last      = 1'b0;
    w_start     = 1'b0;
    unique case (r_state)
      CAP_IDLE, CAP_DONE: begin
        if (cr_start) begin
          w_start     = 1'b1;
          w_state_nxt = CAP_CAPTURE;
        end
      end
      CAP_CAPTURE: begin
        if (din_valid) begin
          w_we = 1'b1;
          if (r_count == LAST_IDX) begin
            w_last      = 1'b1;
            w_state_nxt = CAP_DONE;
          end
        end
      end
      default: w_state_nxt = CAP_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= CAP_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      r_count <= '0;
      r_rd_ok <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt == CAP_CAPTURE);
      r_rd_ok <= 1'b1;
      if (w_start) begin
        r_count <= '0;
        r_done  <= 1'b0;
        r_ovr   <= 1'b0;
      end
      if (r_state == CAP_CAPTURE && cr_start) begin
        r_ovr <= 1'b1;
      end
      if (w_we) begin
        r_count <= r_count + 1'b1;
      end
      if (w_last) begin
        r_done <= 1'b1;
      end
    end
  end

  data_read_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (S_AXI_ACLK),
    .i_we    (w_we),
    .i_waddr (r_count[ADDR_W-1:0]),
    .i_wdata (din),
    .i_raddr (buf_raddr),
    .o_rdata (w_rdata)
  );

  // RAM output register stays unreset for BRAM inference; an async-cleared
  // qualifier forces buf_rdata to zero until the first post-reset read lands.
  assign buf_rdata = r_rd_ok ? 32'(w_rdata) : '0;
  assign sr_busy   = r_busy;
  assign sr_done   = r_done;
  assign sr_ovr    = r_ovr;
  assign sr_count  = r_count;

endmodule

// File: tb/tb_data_read_capture.sv
// Self-checking bench for data_read_capture (DEPTH=8): a transaction-level
// model checked every cycle, plus directed literal expectations.
module tb_data_read_capture;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cr_start = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic [ADDR_W-1:0] buf_raddr = '0;
  logic [31:0]       buf_rdata;
  logic              sr_busy;
  logic              sr_done;
  logic              sr_ovr;
  logic [ADDR_W:0]   sr_count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  data_read_capture #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .cr_start      (cr_start),
    .din           (din),
    .din_valid     (din_valid),
    .buf_raddr     (buf_raddr),
    .buf_rdata     (buf_rdata),
    .sr_busy       (sr_busy),
    .sr_done       (sr_done),
    .sr_ovr        (sr_ovr),
    .sr_count      (sr_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: a burst is "active" between an accepted start and the
  // DEPTH-th strobed sample; the buffer is a plain array read before written.
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_ovr    = 1'b0;
  int          m_count  = 0;
  logic [31:0] m_rdata  = '0;
  bit          m_rknown = 1'b1;
  logic [15:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_ovr    = 1'b0;
      m_count  = 0;
      m_rdata  = '0;
      m_rknown = 1'b1;
    end else begin
      m_rknown = m_wr[buf_raddr];
      m_rdata  = {16'h0000, m_mem[buf_raddr]};
      if (!m_active) begin
        if (cr_start) begin
          m_active = 1'b1;
          m_count  = 0;
          m_done   = 1'b0;
          m_ovr    = 1'b0;
        end
      end else begin
        if (cr_start) m_ovr = 1'b1;
        if (din_valid) begin
          m_mem[m_count % DEPTH] = din;
          m_wr[m_count % DEPTH]  = 1'b1;
          m_count = m_count + 1;
          if (m_count == DEPTH) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy",  32'(sr_busy),  32'(m_active));
      chk("m_done",  32'(sr_done),  32'(m_done));
      chk("m_ovr",   32'(sr_ovr),   32'(m_ovr));
      chk("m_count", 32'(sr_count), 32'(m_count));
      if (m_rknown) chk("m_rdata", buf_rdata, m_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    cr_start = 1'b1;
    step();
    cr_start = 1'b0;
  endtask

  task automatic sample(input logic [15:0] d);
    din       = d;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp);
    buf_raddr = ADDR_W'(a);
    step();
    chk("rd", buf_rdata, exp);
  endtask

  logic [15:0] v6 [DEPTH];

  initial begin
    #12 rst_n = 1'b1;
    step();
    chk_en = 1'b1;
    chk("rst_busy",  32'(sr_busy),  32'd0);
    chk("rst_done",  32'(sr_done),  32'd0);
    chk("rst_count", 32'(sr_count), 32'd0);
    chk("rst_rdata", buf_rdata,     32'd0);

    // Straight burst of 8 samples
    start();
    chk("t1_busy", 32'(sr_busy), 32'd1);
    for (int i = 0; i < 8; i++) sample(16'h1000 + 16'(i));
    chk("t1_done",  32'(sr_done),  32'd1);
    chk("t1_busy0", 32'(sr_busy),  32'd0);
    chk("t1_count", 32'(sr_count), 32'd8);
    for (int i = 0; i < 8; i++) rd(i, 32'h0000_1000 + 32'(i));

    // Gapped strobes 1-0-0-1
    start();
    for (int i = 0; i < 8; i++) begin
      sample(16'h2000 + 16'(i));
      chk("t2_count", 32'(sr_count), 32'(i + 1));
      if (i < 7) begin
        step();
        step();
        chk("t2_hold", 32'(sr_count), 32'(i + 1));
      end
    end
    chk("t2_done", 32'(sr_done), 32'd1);
    for (int i = 0; i < 8; i++) rd(i, 32'h0000_2000 + 32'(i));

    // Start coincident with a strobe from IDLE
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    cr_start  = 1'b1;
    din_valid = 1'b1;
    din       = 16'hDEAD;
    step();
    cr_start  = 1'b0;
    din_valid = 1'b0;
    chk("t3_count0", 32'(sr_count), 32'd0);
    for (int i = 0; i < 8; i++) sample(16'(i + 1));
    for (int i = 0; i < 8; i++) rd(i, 32'(i + 1));

    // Overrun mid-burst and on the final sample
    start();
    for (int i = 0; i < 3; i++) sample(16'h3000 + 16'(i));
    cr_start = 1'b1;
    step();
    cr_start = 1'b0;
    chk("t4_ovr",   32'(sr_ovr),   32'd1);
    chk("t4_count", 32'(sr_count), 32'd3);
    for (int i = 3; i < 7; i++) sample(16'h3000 + 16'(i));
    cr_start = 1'b1;
    sample(16'h3007);
    cr_start = 1'b0;
    chk("t4_done",  32'(sr_done),  32'd1);
    chk("t4_busy",  32'(sr_busy),  32'd0);
    chk("t4_cnt8",  32'(sr_count), 32'd8);
    for (int i = 0; i < 8; i++) rd(i, 32'h0000_3000 + 32'(i));
    start();
    chk("t4_ovr0",  32'(sr_ovr),   32'd0);
    chk("t4_done0", 32'(sr_done),  32'd0);
    chk("t4_cnt0",  32'(sr_count), 32'd0);
    chk("t4_busy1", 32'(sr_busy),  32'd1);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) sample(16'h4000 + 16'(i));
    #3 rst_n = 1'b0;
    #1;
    chk("t5_busy",  32'(sr_busy),  32'd0);
    chk("t5_done",  32'(sr_done),  32'd0);
    chk("t5_ovr",   32'(sr_ovr),   32'd0);
    chk("t5_count", 32'(sr_count), 32'd0);
    chk("t5_rdata", buf_rdata,     32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) sample(16'h4100 + 16'(i));
    chk("t5_idle",  32'(sr_busy),  32'd0);
    chk("t5_cnt",   32'(sr_count), 32'd0);

    // Read-first on a same-address write
    for (int i = 0; i < 8; i++) v6[i] = (i == 2) ? 16'h0055 : 16'h0060 + 16'(i);
    start();
    for (int i = 0; i < 8; i++) sample(v6[i]);
    start();
    sample(16'h0070);
    sample(16'h0071);
    buf_raddr = 3'd2;
    sample(16'h00AA);
    chk("t6_old", buf_rdata, 32'h0000_0055);
    step();
    chk("t6_new", buf_rdata, 32'h0000_00AA);
    for (int i = 3; i < 8; i++) sample(16'h0070 + 16'(i));
    rd(2, 32'h0000_00AA);
    rd(0, 32'h0000_0070);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_read_capture.md
Name: data_read_capture

Overview:
- Downstream consumer of the CR.START pulse produced by the data_read AXI-lite write slave.
- On each accepted start, captures a fixed-length burst of samples from an external parallel data port into an internal buffer.
- Exposes busy/done/overrun/count status and a synchronous buffer read port to the AXI-lite read slave.
- Single clock domain: the AXI clock. The external source is already synchronous to it.

Parameters:
- DATA_W, 16, sample width in bits (1..32).
- DEPTH, 256, samples per burst. Must be a power of two, 2..1024.
- ADDR_W, 8, buffer address width. Must equal log2(DEPTH).

Ports:
- S_AXI_ACLK  in  1  system/AXI clock, rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- cr_start  in  1  one-cycle start request (CR.START).
- din  in  DATA_W  external sample data.
- din_valid  in  1  sample strobe; one sample per high cycle.
- buf_raddr  in  ADDR_W  buffer read address from the AXI read side.
- buf_rdata  out  32  buffer read data, zero-extended from DATA_W.
- sr_busy  out  1  capture in progress.
- sr_done  out  1  burst complete (sticky).
- sr_ovr  out  1  start requested while busy (sticky).
- sr_count  out  ADDR_W+1  samples written in the current or last burst.

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. Reset S_AXI_ARESETN is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - sr_busy = 0, sr_done = 0, sr_ovr = 0, sr_count = 0, buf_rdata = 0.
  - Buffer contents are not reset (RAM).
- FSM states: IDLE, CAPTURE, DONE. The encoding is defined in the shared header.
- Transitions:
  - IDLE or DONE, cr_start=1 -> CAPTURE next cycle. On the same edge: sr_count <= 0, sr_done <= 0, sr_ovr <= 0.
  - CAPTURE, din_valid=1 -> write din to buf[sr_count[ADDR_W-1:0]], then sr_count <= sr_count+1.
  - CAPTURE, din_valid=1 and sr_count == DEPTH-1 -> last write. State becomes DONE, sr_done <= 1, sr_count <= DEPTH.
  - CAPTURE, din_valid=0 -> hold. There is no timeout.
  - DONE -> stays in DONE until cr_start.
- Status outputs are registered:
  - sr_busy = 1 exactly while state == CAPTURE.
  - sr_done asserts on the cycle after the last sample is written.
- Simultaneous events:
  - cr_start and din_valid in the same cycle while IDLE/DONE: that sample is NOT captured. The first captured sample is the first din_valid seen in CAPTURE.
  - cr_start in CAPTURE is ignored for capture purposes: sr_ovr <= 1 and the burst continues unchanged. This includes the final-sample cycle.
- din_valid outside CAPTURE: ignored, no write, count unchanged.
- Read port:
  - buf_rdata <= {zero-extend, buf[buf_raddr]} every cycle; 1-cycle latency.
  - Reads are legal in any state.
  - Same-cycle read and write to the same address returns the OLD data (read-first).
- Reset mid-capture: immediate return to IDLE with all status cleared. Partial buffer data is retained but not flagged valid.
- Width rules:
  - sr_count is ADDR_W+1 bits, so DEPTH is representable.
  - The buffer write address uses the low ADDR_W bits of sr_count. Wrap never occurs because the burst ends at DEPTH.

Decomposition:
- data_read_common.hv gains:
  - state localparams: CAP_IDLE, CAP_CAPTURE, CAP_DONE.
  - status-register bit positions: SR_BUSY=0, SR_DONE=1, SR_OVR=2, SR_COUNT LSB=16.
  - AXI_ADDR_SR, plus the buffer base address AXI_ADDR_BUF used by the read slave.
- One sub-module: data_read_buf.
  - Simple dual-port RAM, DEPTH x DATA_W, one synchronous write port and one synchronous read port, read-first.
  - Must be inferable as block RAM.
- The FSM and counters live in data_read_capture.

Test Plan (bench uses DEPTH=8, ADDR_W=3, DATA_W=16):
- Reset, then pulse cr_start and drive 8 consecutive din_valid with din=0x1000..0x1007.
  -> sr_busy=1 from the cycle after start; sr_done=1, sr_busy=0 and sr_count=8 one cycle after the 8th sample.
  -> Reads of addr 0..7 return 0x00001000..0x00001007, each valid 1 cycle after the address is applied.
- Start, then 8 samples with din_valid toggling 1-0-0-1 gaps.
  -> Only strobed values are stored, in order; sr_count steps 0..8 only on strobe cycles.
- Assert cr_start together with din_valid=1, din=0xDEAD while IDLE, then 8 samples 0x0001..0x0008.
  -> addr 0 reads 0x0001; 0xDEAD appears nowhere in the buffer.
- Pulse cr_start after 3 samples of a burst.
  -> sr_ovr=1, the burst completes at 8 samples with data intact.
  -> The next start from DONE clears sr_ovr and sr_done and resets sr_count to 0.
- Deassert S_AXI_ARESETN asynchronously (mid-cycle) after 5 samples.
  -> All status outputs are 0 immediately; buf_rdata=0.
  -> After release, state is IDLE and din_valid is ignored until cr_start.
- Write addr 2 with 0x00AA on the same cycle buf_raddr=2, previous content 0x0055.
  -> buf_rdata=0x00000055 next cycle, then 0x000000AA on the following read.
